// File: rtl/f5_seq_ctrl.sv
// F5 feature-map buffer sequencer: counts parallel writes into the common address and
// streams all NUM_MAP x DEPTH words map-major with the buffer's skewed sel/addr timing.
module f5_seq_ctrl #(
  parameter int DEPTH   = 25,
  parameter int NUM_MAP = 16,
  parameter int ADDR_W  = 5,
  parameter int RD_LAT  = 3,
  parameter int SEL_W   = 4,
  parameter int IDX_W   = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              f5_wr_en,
  output logic [ADDR_W-1:0] f5_waddr,
  output logic              buf_full,
  output logic              wr_overflow,
  input  logic              rd_start,
  output logic [SEL_W-1:0]  f5_sel,
  output logic [ADDR_W-1:0] f5_raddr,
  output logic              rd_valid,
  output logic              rd_last,
  output logic [IDX_W-1:0]  rd_idx,
  output logic              busy
);
  typedef enum logic       {W_FILL, W_FULL} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_DRAIN} r_state_t;

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_MAP * DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(DEPTH - 1);
  localparam logic [SEL_W-1:0]  LAST_M   = SEL_W'(NUM_MAP - 1);

  w_state_t                        w_state;
  r_state_t                        r_state;
  logic [ADDR_W-1:0]               rd_a;
  logic [IDX_W-1:0]                iss_idx;
  logic                            iss_v;
  logic [RD_LAT:1]                 vld_pipe;
  logic [RD_LAT:1][IDX_W-1:0]      idx_pipe;

  assign f5_wr_en = wr_valid & ~buf_full;
  assign iss_v    = (r_state == R_ISSUE);
  assign rd_valid = vld_pipe[RD_LAT];
  assign rd_idx   = idx_pipe[RD_LAT];
  assign rd_last  = rd_valid && (rd_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state     <= W_FILL;
      r_state     <= R_IDLE;
      f5_waddr    <= '0;
      buf_full    <= 1'b0;
      wr_overflow <= 1'b0;
      f5_sel      <= '0;
      f5_raddr    <= '0;
      rd_a        <= '0;
      iss_idx     <= '0;
      busy        <= 1'b0;
      vld_pipe    <= '0;
      idx_pipe    <= '0;
    end else begin
      // Write side: f5_waddr is the row counter itself.
      if (rd_last) begin
        w_state  <= W_FILL;
        buf_full <= 1'b0;
      end else if (f5_wr_en) begin
        if (f5_waddr == LAST_A) begin
          f5_waddr <= '0;
          w_state  <= W_FULL;
          buf_full <= 1'b1;
        end else begin
          f5_waddr <= f5_waddr + 1'b1;
        end
      end
      if (wr_valid && buf_full) wr_overflow <= 1'b1;

      // Read side: f5_sel carries the issue-cycle map, f5_raddr lags it by one cycle.
      case (r_state)
        R_IDLE: if (rd_start && buf_full) begin
          r_state <= R_ISSUE;
          busy    <= 1'b1;
          f5_sel  <= '0;
          rd_a    <= '0;
          iss_idx <= '0;
        end
        R_ISSUE: begin
          f5_raddr <= rd_a;
          iss_idx  <= iss_idx + 1'b1;
          if (rd_a == LAST_A) begin
            rd_a <= '0;
            if (f5_sel == LAST_M) r_state <= R_DRAIN;
            else                  f5_sel  <= f5_sel + 1'b1;
          end else begin
            rd_a <= rd_a + 1'b1;
          end
        end
        R_DRAIN: if (rd_last) begin
          r_state <= R_IDLE;
          busy    <= 1'b0;
        end
        default: r_state <= R_IDLE;
      endcase

      vld_pipe[1] <= iss_v;
      idx_pipe[1] <= iss_idx;
      for (int i = 2; i <= RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end
    end
  end
endmodule

// File: tb/tb_f5_seq_ctrl.sv
// Randomized bench for f5_seq_ctrl against a cycle-count reference model and a
// behavioural feature-map buffer (2-stage select, 1-stage address, registered mux).
module tb_f5_seq_ctrl;
  localparam int DEPTH = 25;
  localparam int TOTAL = 16 * DEPTH;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic       rd_start = 1'b0;
  logic       f5_wr_en, buf_full, wr_overflow, rd_valid, rd_last, busy;
  logic [4:0] f5_waddr, f5_raddr;
  logic [3:0] f5_sel;
  logic [8:0] rd_idx;

  int n_cmp = 0, n_err = 0;
  int exp_idx = 0, n_v = 0, last_cnt = 0, n_streams = 0;

  f5_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .f5_wr_en(f5_wr_en),
    .f5_waddr(f5_waddr), .buf_full(buf_full), .wr_overflow(wr_overflow),
    .rd_start(rd_start), .f5_sel(f5_sel), .f5_raddr(f5_raddr),
    .rd_valid(rd_valid), .rd_last(rd_last), .rd_idx(rd_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  // Buffer preloaded with word = sel*32 + addr.
  logic [3:0]  sel_q1, sel_q2;
  logic [4:0]  addr_q;
  logic [15:0] bm_data;
  always @(posedge clk) begin
    sel_q1  <= f5_sel;
    sel_q2  <= sel_q1;
    addr_q  <= f5_raddr;
    bm_data <= 16'(sel_q2) * 16'd32 + 16'(addr_q);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Stream scoreboard, evaluated once per cycle.
  task automatic mon();
    if (!rst_n) begin
      exp_idx = 0;
      n_v     = 0;
    end else if (rd_valid) begin
      chk("rd_idx", int'(rd_idx), exp_idx);
      chk("rd_data", int'(bm_data), (exp_idx / DEPTH) * 32 + (exp_idx % DEPTH));
      chk("rd_last", int'(rd_last), int'(exp_idx == TOTAL - 1));
      n_v++;
      if (exp_idx == TOTAL - 1) begin
        last_cnt = n_v;
        n_streams++;
        n_v     = 0;
        exp_idx = 0;
      end else begin
        exp_idx++;
      end
    end else begin
      chk("rd_last_idle", int'(rd_last), 0);
      if (n_v != 0) chk("rd_gap", int'(rd_valid), 1);
    end
  endtask

  task automatic cyc(input logic wv, input logic rs, input logic rn);
    @(negedge clk);
    wr_valid = wv;
    rd_start = rs;
    rst_n    = rn;
    #1;
    mon();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sel"}, int'(f5_sel), 0);
    chk({tag, "_raddr"}, int'(f5_raddr), 0);
    chk({tag, "_waddr"}, int'(f5_waddr), 0);
    chk({tag, "_full"}, int'(buf_full), 0);
    chk({tag, "_ovf"}, int'(wr_overflow), 0);
    chk({tag, "_vld"}, int'(rd_valid), 0);
    chk({tag, "_last"}, int'(rd_last), 0);
    chk({tag, "_idx"}, int'(rd_idx), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  // Random-gap fill of DEPTH rows with stray rd_start pulses (all must be ignored).
  task automatic fill();
    int w = 0;
    int guard = 0;
    logic wv;
    while (w < DEPTH && guard < 500) begin
      wv = 1'($urandom_range(0, 1));
      cyc(wv, ($urandom % 4) == 0, 1'b1);
      chk("fill_wr_en", int'(f5_wr_en), int'(wv));
      chk("fill_full", int'(buf_full), 0);
      chk("fill_busy", int'(busy), 0);
      if (wv) begin
        chk("fill_waddr", int'(f5_waddr), w);
        w++;
      end
      guard++;
    end
    chk("fill_done", w, DEPTH);
    cyc(1'b0, 1'b0, 1'b1);
    chk("full_after_fill", int'(buf_full), 1);
    chk("busy_after_fill", int'(busy), 0);
  endtask

  // Full stream; with late_wv, wr_valid rises on the expected rd_last cycle and stays high.
  task automatic run_stream(input bit late_wv);
    bit seen = 0;
    int c;
    logic wv;
    int n0 = n_streams;
    cyc(1'b0, 1'b1, 1'b1);
    chk("busy_c0", int'(busy), 0);
    for (c = 1; c < 600 && !seen; c++) begin
      wv = late_wv && (c >= 403);
      cyc(wv, ($urandom % 8) == 0, 1'b1);
      chk("sel_seq", int'(f5_sel), (c <= TOTAL) ? (c - 1) / DEPTH : 15);
      if (c >= 2) chk("raddr_seq", int'(f5_raddr), (c <= TOTAL + 1) ? (c - 2) % DEPTH : DEPTH - 1);
      if (c < 4) chk("vld_early", int'(rd_valid), 0);
      if (c == 4) begin
        chk("first_vld", int'(rd_valid), 1);
        chk("first_idx", int'(rd_idx), 0);
      end
      chk("busy_run", int'(busy), 1);
      if (late_wv && c == 402) chk("ovf_pre_last", int'(wr_overflow), 0);
      if (rd_last) begin
        seen = 1;
        chk("last_cycle", c, TOTAL + 3);
        chk("last_full", int'(buf_full), 1);
        if (late_wv) chk("wr_on_last", int'(f5_wr_en), 0);
      end
    end
    chk("rd_last_seen", int'(seen), 1);
    cyc(late_wv, 1'b0, 1'b1);
    chk("busy_after", int'(busy), 0);
    chk("full_after", int'(buf_full), 0);
    chk("vld_after", int'(rd_valid), 0);
    chk("stream_cnt", last_cnt, TOTAL);
    chk("streams", n_streams, n0 + 1);
    if (late_wv) begin
      chk("ovf_after_last", int'(wr_overflow), 1);
      chk("wr_after_last", int'(f5_wr_en), 1);
      chk("waddr_after_last", int'(f5_waddr), 0);
    end
  endtask

  initial begin
    int guard;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    chk_zero("rst");

    fill();
    run_stream(1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      chk("idle_vld", int'(rd_valid), 0);
    end

    fill();
    chk("ovf_clean", int'(wr_overflow), 0);
    run_stream(1'b1);

    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    chk_zero("rst2");
    fill();
    cyc(1'b1, 1'b0, 1'b1);
    chk("wr_when_full", int'(f5_wr_en), 0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("ovf_sticky", int'(wr_overflow), 1);
    chk("full_kept", int'(buf_full), 1);

    // Abort a stream mid-flight with reset.
    cyc(1'b0, 1'b1, 1'b1);
    guard = 0;
    while (!(rd_valid && rd_idx >= 9'd150) && guard < 300) begin
      cyc(1'b0, 1'b0, 1'b1);
      guard++;
    end
    chk("mid_reached", int'(rd_valid && rd_idx >= 9'd150), 1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    chk_zero("rst_mid");
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      chk("post_rst_vld", int'(rd_valid), 0);
      chk("post_rst_busy", int'(busy), 0);
    end
    fill();
    run_stream(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
